// File: rtl/wt_direct_mapped_cache_pkg.sv
// Shared types for the write-through direct-mapped cache: FSM states, memory
// request encoding and the byte-merge helper used by the line array.
package wt_direct_mapped_cache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOOKUP    = 3'd1,
      ST_MISS_REQ  = 3'd2,
      ST_MISS_WAIT = 3'd3,
      ST_WRITE     = 3'd4
   } state_t;

   localparam logic MEM_RW_READ  = 1'b0;
   localparam logic MEM_RW_WRITE = 1'b1;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
      logic [31:0] result;
      result = old_word;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) result[8*b +: 8] = new_word[8*b +: 8];
      end
      return result;
   endfunction

endpackage

// File: rtl/wt_direct_mapped_cache_cache_line_array.sv
// Valid/tag/data storage for one-word lines; combinational read, one byte-masked
// write port (fill also sets tag and valid); reset invalidates every line at once.
module cache_line_array
   import wt_direct_mapped_cache_pkg::*;
#(
   parameter int INDEX_BITS = 6,
   parameter int TAG_W      = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INDEX_BITS-1:0] idx,
   output logic                  rd_valid,
   output logic [TAG_W-1:0]      rd_tag,
   output logic [31:0]           rd_data,
   input  logic                  wr_en,
   input  logic                  wr_fill,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [31:0]           wr_data,
   input  logic [3:0]            wr_mask
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   assign rd_valid = valid_q[idx];
   assign rd_tag   = tag_q[idx];
   assign rd_data  = data_q[idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else if (wr_en && wr_fill) begin
         valid_q[idx] <= 1'b1;
      end
   end

   // Tag/data need no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_q[idx] <= merge_bytes(data_q[idx], wr_data, wr_mask);
         if (wr_fill) tag_q[idx] <= wr_tag;
      end
   end

endmodule

// File: rtl/wt_direct_mapped_cache.sv
// Write-through, no-write-allocate direct-mapped cache; read hit answers 1 cycle after
// accept, misses forward memory data in the response cycle; requests stall while busy.
module wt_direct_mapped_cache
   import wt_direct_mapped_cache_pkg::*;
#(
   parameter int INDEX_BITS = 6,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_re,
   input  logic [3:0]        cpu_we,
   input  logic [31:0]       cpu_din,
   output logic [31:0]       cpu_dout,
   output logic              cpu_req_ready,
   output logic              cpu_resp_valid,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_rw,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [31:0]       mem_req_data,
   output logic [3:0]        mem_req_mask,
   input  logic              mem_resp_valid,
   input  logic [31:0]       mem_resp_data
);

   localparam int                TAG_W     = ADDR_W - INDEX_BITS - 2;
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

   state_t            state;
   logic [ADDR_W-1:0] req_addr;
   logic [3:0]        req_we;
   logic [31:0]       req_din;
   logic              wr_first;

   logic                  arr_valid;
   logic [TAG_W-1:0]      arr_tag;
   logic [31:0]           arr_data;
   logic [INDEX_BITS-1:0] req_idx;
   logic [TAG_W-1:0]      req_tag;
   logic                  hit, lookup_hit, fill, accept, arr_wr_en;

   assign req_idx    = req_addr[INDEX_BITS+1:2];
   assign req_tag    = req_addr[ADDR_W-1:INDEX_BITS+2];
   assign hit        = arr_valid && (arr_tag == req_tag);
   assign lookup_hit = (state == ST_LOOKUP) && hit;
   assign fill       = (state == ST_MISS_WAIT) && mem_resp_valid;

   assign cpu_req_ready  = (state == ST_IDLE) || lookup_hit;
   assign accept         = cpu_req_ready && (cpu_re || (cpu_we != 4'b0000));
   assign cpu_resp_valid = lookup_hit || fill;
   assign cpu_dout       = lookup_hit ? arr_data : (fill ? mem_resp_data : 32'h0);

   assign mem_req_valid = (state == ST_MISS_REQ) || (state == ST_WRITE);
   assign mem_req_rw    = (state == ST_WRITE) ? MEM_RW_WRITE : MEM_RW_READ;
   assign mem_req_addr  = mem_req_valid ? (req_addr & WORD_MASK) : '0;
   assign mem_req_data  = (state == ST_WRITE) ? req_din : 32'h0;
   assign mem_req_mask  = (state == ST_WRITE) ? req_we : 4'h0;

   // A write hit merges only on the first WRITE cycle; later stall cycles must not rewrite.
   assign arr_wr_en = fill || ((state == ST_WRITE) && wr_first && hit);

   cache_line_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_W      (TAG_W)
   ) u_lines (
      .clk      (clk),
      .reset    (reset),
      .idx      (req_idx),
      .rd_valid (arr_valid),
      .rd_tag   (arr_tag),
      .rd_data  (arr_data),
      .wr_en    (arr_wr_en),
      .wr_fill  (fill),
      .wr_tag   (req_tag),
      .wr_data  (fill ? mem_resp_data : req_din),
      .wr_mask  (fill ? 4'hF : req_we)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         req_addr <= '0;
         req_we   <= 4'h0;
         req_din  <= 32'h0;
         wr_first <= 1'b0;
      end else begin
         wr_first <= 1'b0;
         if (accept) begin
            req_addr <= cpu_addr;
            req_we   <= cpu_we;
            req_din  <= cpu_din;
            wr_first <= (cpu_we != 4'b0000);
            state    <= (cpu_we != 4'b0000) ? ST_WRITE : ST_LOOKUP;
         end else begin
            case (state)
               ST_IDLE:      state <= ST_IDLE;
               ST_LOOKUP:    state <= hit ? ST_IDLE : ST_MISS_REQ;
               ST_MISS_REQ:  if (mem_req_ready) state <= ST_MISS_WAIT;
               ST_MISS_WAIT: if (mem_resp_valid) state <= ST_IDLE;
               ST_WRITE:     if (mem_req_ready) state <= ST_IDLE;
               default:      state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
